// File: rtl/tft_spi_sniffer_if.sv
// Bus bundle for tft_spi_sniffer: the passive SPI tap inputs, the byte
// stream valid/ready handshake, and the decoded pixel strobe outputs.
interface tft_spi_sniffer_if;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_dc;
    logic        spi_cs;
    logic [7:0]  rx_data;
    logic        rx_dc;
    logic        rx_valid;
    logic        rx_ready;
    logic        overflow;
    logic        px_valid;
    logic [15:0] px_x;
    logic [15:0] px_y;
    logic [15:0] px_color;
    logic        busy;

    // Sniffer side: watches the bus, sources bytes and pixels.
    modport slave (
        input  spi_clk, spi_mosi, spi_dc, spi_cs, rx_ready,
        output rx_data, rx_dc, rx_valid, overflow,
        output px_valid, px_x, px_y, px_color, busy
    );

    // Environment side: drives the SPI wires and consumes bytes/pixels.
    modport master (
        output spi_clk, spi_mosi, spi_dc, spi_cs, rx_ready,
        input  rx_data, rx_dc, rx_valid, overflow,
        input  px_valid, px_x, px_y, px_color, busy
    );
endinterface

// File: rtl/tft_spi_sniffer.sv
// Passive TFT SPI receiver: resynchronises the 4-wire bus into clk,
// rebuilds dc-tagged bytes, queues them in a small FIFO and decodes the
// ILI9341 CASET/RASET/RAMWR sequences into a pixel strobe.
module tft_spi_sniffer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    tft_spi_sniffer_if.slave  bus
);
    localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_RASET,
        ST_RAMWR_HI,
        ST_RAMWR_LO
    } state_t;

    // ---------------- input conditioning ----------------
    // bit order within each stage: {clk, mosi, dc, cs}
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_d [SYNC_STAGES];
    logic       sclk_prev_q, sclk_prev_d;
    logic       s_clk, s_mosi, s_dc, s_cs, rise;

    // Shift each SPI wire through the synchroniser chain.
    always_comb begin
        sync_d[0] = {bus.spi_clk, bus.spi_mosi, bus.spi_dc, bus.spi_cs};
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign s_clk       = sync_q[SYNC_STAGES-1][3];
    assign s_mosi      = sync_q[SYNC_STAGES-1][2];
    assign s_dc        = sync_q[SYNC_STAGES-1][1];
    assign s_cs        = sync_q[SYNC_STAGES-1][0];
    assign sclk_prev_d = s_clk;
    assign rise        = s_clk & ~sclk_prev_q;

    // Synchroniser and edge-detect registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            sclk_prev_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            sclk_prev_q <= sclk_prev_d;
        end
    end

    // ---------------- byte assembly ----------------
    logic [6:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       byte_done_q, byte_done_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic       byte_dc_q, byte_dc_d;

    // Shift MSB-first on each rising edge while selected; cs high discards.
    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        byte_done_d = 1'b0;
        byte_data_d = byte_data_q;
        byte_dc_d   = byte_dc_q;
        if (s_cs) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (rise) begin
            shift_d = {shift_q[5:0], s_mosi};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                byte_done_d = 1'b1;
                byte_data_d = {shift_q, s_mosi};
                byte_dc_d   = s_dc;
            end
        end
    end

    // Byte assembler registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            byte_done_q <= 1'b0;
            byte_data_q <= '0;
            byte_dc_q   <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            byte_done_q <= byte_done_d;
            byte_data_q <= byte_data_d;
            byte_dc_q   <= byte_dc_d;
        end
    end

    // ---------------- byte FIFO ----------------
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [8:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, pop, push_ok;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop     = (count_q != '0) & bus.rx_ready;
    // a pop in the same cycle frees the slot the push needs
    assign push_ok = byte_done_q & (~full | pop);

    // FIFO pointer, occupancy and overflow update.
    always_comb begin
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = {byte_dc_q, byte_data_q};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
        if (byte_done_q && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO storage and control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.rx_data  = mem_q[rd_ptr_q][7:0];
    assign bus.rx_dc    = mem_q[rd_ptr_q][8];
    assign bus.rx_valid = (count_q != '0);
    assign bus.overflow = overflow_q;

    // ---------------- command decoder ----------------
    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] sh_q, sh_d;
    logic [15:0] x_start_q, x_start_d, x_end_q, x_end_d;
    logic [15:0] y_start_q, y_start_d, y_end_q, y_end_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic [7:0]  color_hi_q, color_hi_d;
    logic        px_valid_q, px_valid_d;
    logic [15:0] px_x_q, px_x_d, px_y_q, px_y_d, px_color_q, px_color_d;

    // Next-state and register updates for the ILI9341 command decoder.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sh_d       = sh_q;
        x_start_d  = x_start_q;
        x_end_d    = x_end_q;
        y_start_d  = y_start_q;
        y_end_d    = y_end_q;
        x_d        = x_q;
        y_d        = y_q;
        color_hi_d = color_hi_q;
        px_valid_d = 1'b0;
        px_x_d     = px_x_q;
        px_y_d     = px_y_q;
        px_color_d = px_color_q;
        if (byte_done_q) begin
            if (!byte_dc_q) begin
                idx_d = '0;
                case (byte_data_q)
                    8'h2A:   state_d = ST_CASET;
                    8'h2B:   state_d = ST_RASET;
                    8'h2C: begin
                        state_d = ST_RAMWR_HI;
                        x_d     = x_start_q;
                        y_d     = y_start_q;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end else begin
                case (state_q)
                    ST_CASET, ST_RASET: begin
                        // first three bytes are staged so a truncated
                        // sequence never disturbs the live window
                        sh_d  = {sh_q[15:0], byte_data_q};
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            if (state_q == ST_CASET) begin
                                x_start_d = sh_q[23:8];
                                x_end_d   = {sh_q[7:0], byte_data_q};
                            end else begin
                                y_start_d = sh_q[23:8];
                                y_end_d   = {sh_q[7:0], byte_data_q};
                            end
                            state_d = ST_IDLE;
                        end
                    end
                    ST_RAMWR_HI: begin
                        color_hi_d = byte_data_q;
                        state_d    = ST_RAMWR_LO;
                    end
                    ST_RAMWR_LO: begin
                        px_valid_d = 1'b1;
                        px_x_d     = x_q;
                        px_y_d     = y_q;
                        px_color_d = {color_hi_q, byte_data_q};
                        state_d    = ST_RAMWR_HI;
                        // strobe captures the old position; advance now
                        if (x_q == x_end_q) begin
                            x_d = x_start_q;
                            y_d = (y_q == y_end_q) ? y_start_q : y_q + 16'd1;
                        end else begin
                            x_d = x_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Decoder state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            sh_q       <= '0;
            x_start_q  <= '0;
            x_end_q    <= 16'd239;
            y_start_q  <= '0;
            y_end_q    <= 16'd319;
            x_q        <= '0;
            y_q        <= '0;
            color_hi_q <= '0;
            px_valid_q <= 1'b0;
            px_x_q     <= '0;
            px_y_q     <= '0;
            px_color_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sh_q       <= sh_d;
            x_start_q  <= x_start_d;
            x_end_q    <= x_end_d;
            y_start_q  <= y_start_d;
            y_end_q    <= y_end_d;
            x_q        <= x_d;
            y_q        <= y_d;
            color_hi_q <= color_hi_d;
            px_valid_q <= px_valid_d;
            px_x_q     <= px_x_d;
            px_y_q     <= px_y_d;
            px_color_q <= px_color_d;
        end
    end

    assign bus.px_valid = px_valid_q;
    assign bus.px_x     = px_x_q;
    assign bus.px_y     = px_y_q;
    assign bus.px_color = px_color_q;
    assign bus.busy     = (cnt_q != 3'd0) | (state_q != ST_IDLE);

endmodule

// File: tb/tb_tft_spi_sniffer.sv
// Directed bench for tft_spi_sniffer: drives SPI bytes slowly relative to
// clk, records popped bytes and pixel strobes, and checks them against
// hand-computed expectations.
module tb_tft_spi_sniffer;
    logic clk;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    int   fails  = 0;

    logic [8:0]  bq [$];
    logic [47:0] pq [$];

    tft_spi_sniffer_if bus();

    tft_spi_sniffer #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted FIFO byte and every pixel strobe.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.rx_valid && bus.rx_ready) bq.push_back({bus.rx_dc, bus.rx_data});
            if (bus.px_valid) pq.push_back({bus.px_x, bus.px_y, bus.px_color});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b);
        bus.spi_clk  = 1'b0;
        bus.spi_mosi = b;
        repeat (4) @(negedge clk);
        bus.spi_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        bus.spi_dc = dc;
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
        bus.spi_clk = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        rst          = 1'b0;
        bus.spi_clk  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_dc   = 1'b0;
        bus.spi_cs   = 1'b0;
        bus.rx_ready = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_rx_valid", 64'(bus.rx_valid), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        check("rst_px_valid", 64'(bus.px_valid), 64'd0);
        check("rst_busy",     64'(bus.busy),     64'd0);
        check("rst_px",       64'({bus.px_x, bus.px_y, bus.px_color}), 64'd0);
        check("rst_rx_data",  64'(bus.rx_data),  64'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // RAMWR straight after reset: default window origin
        send_byte(8'h2C, 1'b0);
        check("ramwr_busy", 64'(bus.busy), 64'd1);
        send_byte(8'hF8, 1'b1);
        send_byte(8'h00, 1'b1);
        check("px0_count", 64'(pq.size()), 64'd1);
        check("px0_value", 64'(pq[0]), 64'({16'd0, 16'd0, 16'hF800}));
        check("fifo_count", 64'(bq.size()), 64'd3);
        check("fifo_b0", 64'(bq[0]), 64'({1'b0, 8'h2C}));
        check("fifo_b1", 64'(bq[1]), 64'({1'b1, 8'hF8}));
        check("fifo_b2", 64'(bq[2]), 64'({1'b1, 8'h00}));

        // window 16..18 x 32..33, six pixels
        pq.delete();
        send_byte(8'h2A, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h12, 1'b1);
        send_byte(8'h2B, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h20, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h21, 1'b1);
        send_byte(8'h2C, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'h0A, 1'b1);
            send_byte(8'(i), 1'b1);
        end
        check("win_count", 64'(pq.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            check("win_px", 64'(pq[i]),
                  64'({16'(16 + i % 3), 16'(32 + i / 3), 16'(16'h0A00 + i)}));
        end

        // truncated CASET leaves the window alone
        pq.delete();
        send_byte(8'h2A, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
        send_byte(8'h2C, 1'b0);
        send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
        send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        check("trunc_count", 64'(pq.size()), 64'd2);
        check("trunc_px0", 64'(pq[0]), 64'({16'd16, 16'd32, 16'hABCD}));
        check("trunc_px1", 64'(pq[1]), 64'({16'd17, 16'd32, 16'h1234}));
        send_byte(8'h00, 1'b0);
        check("nop_busy", 64'(bus.busy), 64'd0);
        check("pre_ovf", 64'(bus.overflow), 64'd0);

        // overflow: six bytes into a four-deep FIFO with no consumer
        @(posedge clk); #1 bus.rx_ready = 1'b0;
        bq.delete();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h11 + i), 1'b1);
        check("ovf_flag", 64'(bus.overflow), 64'd1);
        check("ovf_valid", 64'(bus.rx_valid), 64'd1);
        check("ovf_head", 64'({bus.rx_dc, bus.rx_data}), 64'({1'b1, 8'h11}));
        @(posedge clk); #1 bus.rx_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("drain_count", 64'(bq.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("drain_byte", 64'(bq[i]), 64'({1'b1, 8'(8'h11 + i)}));
        end
        check("drain_valid", 64'(bus.rx_valid), 64'd0);
        check("drain_ovf", 64'(bus.overflow), 64'd1);

        // cs raised mid-byte discards the partial bits
        bq.delete();
        bus.spi_dc = 1'b1;
        for (int i = 0; i < 5; i++) spi_bit(1'b1);
        bus.spi_clk = 1'b0;
        repeat (8) @(negedge clk);
        check("partial_busy", 64'(bus.busy), 64'd1);
        bus.spi_cs = 1'b1;
        repeat (8) @(negedge clk);
        check("cs_busy", 64'(bus.busy), 64'd0);
        bus.spi_cs = 1'b0;
        repeat (8) @(negedge clk);
        send_byte(8'hA5, 1'b1);
        check("cs_count", 64'(bq.size()), 64'd1);
        check("cs_byte", 64'(bq[0]), 64'({1'b1, 8'hA5}));
        check("cs_busy_after", 64'(bus.busy), 64'd0);

        // reset mid-pixel and mid-byte
        bq.delete();
        pq.delete();
        send_byte(8'h2C, 1'b0);
        send_byte(8'h55, 1'b1);
        bus.spi_dc = 1'b1;
        for (int i = 0; i < 4; i++) spi_bit(1'b0);
        bus.spi_clk = 1'b0;
        repeat (2) @(negedge clk);
        bq.delete();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_valid", 64'(bus.rx_valid), 64'd0);
        check("mid_rst_ovf", 64'(bus.overflow), 64'd0);
        check("mid_rst_px", 64'({bus.px_x, bus.px_y}), 64'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'h2C, 1'b0);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        check("post_rst_px_count", 64'(pq.size()), 64'd1);
        check("post_rst_px", 64'(pq[0]), 64'({16'd0, 16'd0, 16'h1234}));
        check("post_rst_fifo_count", 64'(bq.size()), 64'd3);
        check("post_rst_fifo_b0", 64'(bq[0]), 64'({1'b0, 8'h2C}));
        check("post_rst_fifo_b2", 64'(bq[2]), 64'({1'b1, 8'h34}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tft_spi_sniffer.md
Name: tft_spi_sniffer

Overview:
- Receive-side counterpart of tft_spi: passively watches the 4-wire TFT SPI bus (clk/mosi/dc/cs) and rebuilds the byte stream tft_spi transmits.
- Delivers each byte, tagged with its dc value, through a small FIFO with a valid/ready handshake.
- Decodes the ILI9341 CASET (0x2A), RASET (0x2B) and RAMWR (0x2C) sequences into a pixel strobe carrying x, y and RGB565 colour.
- Sits on the analyzer tap of the Maze top level. Used for on-chip checking of init, scene and player traffic and as a simulation scoreboard source.

Parameters:
- FIFO_DEPTH, 4, byte FIFO entries; must be a power of 2, minimum 2.
- SYNC_STAGES, 2, synchroniser flops on each SPI input; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- spi_clk  in  1  SPI clock, mode 0; asynchronous to clk
- spi_mosi  in  1  serial data, MSB first
- spi_dc  in  1  0 = command byte, 1 = data byte
- spi_cs  in  1  active-low chip select; may be tied 0
- rx_data  out  8  byte at FIFO head
- rx_dc  out  1  dc tag of the head byte
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer accepts the head byte when rx_valid & rx_ready
- overflow  out  1  sticky; a byte was dropped because the FIFO was full
- px_valid  out  1  one-clk pixel strobe
- px_x  out  16  pixel column
- px_y  out  16  pixel row
- px_color  out  16  RGB565 colour, first received byte in [15:8]
- busy  out  1  partial byte in progress, or decoder not in IDLE

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; FIFO empty; bit count 0; decoder IDLE; x_start=y_start=0; x_end=239; y_end=319.
- Input conditioning:
  - spi_clk, spi_mosi, spi_dc and spi_cs each pass through SYNC_STAGES flops.
  - A rising edge is detected when the synchronised spi_clk goes 0 to 1.
  - spi_clk high and low phases must each last at least 2 clk periods; faster buses are out of spec.
- Byte assembly:
  - On each detected rising edge with synchronised cs=0, shift in mosi (MSB first) and increment a 3-bit counter.
  - On the 8th bit, sample dc from the same synchronised sample and complete the byte; the counter wraps to 0.
  - While synchronised cs=1, the counter is held at 0 and any partial byte is discarded. Decoder state is kept.
- FIFO:
  - A completed byte is written 1 clk after the detecting edge.
  - rx_valid rises the clk after the write if the FIFO was empty.
  - Pop on rx_valid & rx_ready.
  - Simultaneous push and pop while full: the pop frees a slot, the push succeeds, and overflow stays unchanged.
  - Push while full with no pop: the byte is dropped and overflow is set to 1; it clears only on reset.
  - Output ordering is strictly FIFO; rx_data/rx_dc hold stable while rx_valid=1 and rx_ready=0.
- Decoder:
  - Fed directly from the byte assembler, not from the FIFO, so rx_ready never stalls pixels.
  - States: IDLE, CASET, RASET, RAMWR_HI, RAMWR_LO.
  - A command byte (dc=0) in any state:
    - 0x2A: go to CASET, index 0.
    - 0x2B: go to RASET, index 0.
    - 0x2C: go to RAMWR_HI, with x=x_start and y=y_start.
    - Anything else: go to IDLE.
    - Any partial multi-byte sequence is abandoned.
  - CASET/RASET: data bytes 0..3 load start[15:8], start[7:0], end[15:8], end[7:0]. The new start/end take effect only after byte 3, then the state returns to IDLE. Registers are not range-checked.
  - RAMWR_HI: a data byte loads color[15:8], then go to RAMWR_LO.
  - RAMWR_LO: a data byte loads color[7:0], then go back to RAMWR_HI. px_valid pulses for 1 clk, the cycle after the byte completes, with px_x=x, px_y=y and the full colour. After the pulse, advance the position:
    - If x==x_end: x=x_start; then y=y_start if y==y_end, else y+1.
    - Otherwise x+1, 16-bit wrap.
  - Data bytes in IDLE are ignored.
  - px_x/px_y/px_color hold their values between strobes.
- busy = (bit count != 0) | (decoder != IDLE).
- Reset asserted mid-byte or mid-pixel: everything returns to reset values immediately and no strobe is generated.

Test Plan:
- Send command 0x2A, then data 0x00, 0x10, 0x00, 0x12; command 0x2B, then data 0x00, 0x20, 0x00, 0x21; command 0x2C, then 12 data bytes -> 6 px_valid pulses at (x,y) = (16,32), (17,32), (18,32), (16,33), (17,33), (18,33).
- Pixel bytes 0xF8, 0x00 after RAMWR -> px_color=0xF800. FIFO delivers 0x2C/dc=0, 0xF8/dc=1, 0x00/dc=1 in order.
- Hold rx_ready=0 and send 6 bytes with FIFO_DEPTH=4 -> FIFO holds the first 4 bytes, overflow=1. Release rx_ready -> exactly those 4 bytes drain; overflow stays 1.
- Raise cs after 5 bits, then send byte 0xA5 -> only 0xA5 appears and busy returns to 0 after it.
- Send command 0x2A and 2 data bytes, then command 0x2C and 2 data bytes -> x_start/x_end unchanged; the pixel appears at the previous x_start, y_start.
- After reset, send command 0x2C and 2 data bytes -> px_x=0, px_y=0. With rst pulsed low mid-byte, nothing from the partial byte reaches the FIFO or the decoder.
